// File: rtl/rif_arbiter_if.sv
// Requester and register-file signal bundle for rif_arbiter.
// slave = arbiter side; master = requesters plus register file.
interface rif_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BYTE_COUNT = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*BYTE_COUNT-1:0] req_wstrb;
  logic [NUM_REQ-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;

  logic [ADDR_WIDTH-1:0]         rif_waddr;
  logic [DATA_WIDTH-1:0]         rif_wdata;
  logic [BYTE_COUNT-1:0]         rif_wstrb;
  logic                          rif_wr_req;
  logic                          rif_wvalid;
  logic [ADDR_WIDTH-1:0]         rif_raddr;
  logic                          rif_rd_req;
  logic                          rif_rvalid;
  logic [DATA_WIDTH-1:0]         rif_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb,
    output req_ack, rsp_rdata, rsp_err,
    output rif_waddr, rif_wdata, rif_wstrb, rif_wr_req, rif_raddr, rif_rd_req,
    input  rif_wvalid, rif_rvalid, rif_rdata
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb,
    input  req_ack, rsp_rdata, rsp_err,
    input  rif_waddr, rif_wdata, rif_wstrb, rif_wr_req, rif_raddr, rif_rd_req,
    output rif_wvalid, rif_rvalid, rif_rdata
  );
endinterface

// File: rtl/rif_arbiter.sv
// Round-robin arbiter sharing one RIF port between NUM_REQ requesters, one access in flight.
// Optional macro RIF_ARB_LOCK_EN enables bounded locked re-grants (req_lock, LOCK_MAX).
module rif_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic          aclk,
  input  logic          reset,
  rif_arbiter_if.slave  bus
);
  localparam int unsigned BYTE_COUNT = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       rr_ptr, gnt, win, cand;
  logic                   any_req;
  int unsigned            idx;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;
  logic [BYTE_COUNT-1:0]  wstrb_q;
  logic                   err_q;

  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];
  logic [BYTE_COUNT-1:0]  wstrb_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_arr[i] = bus.req_wstrb[i*BYTE_COUNT +: BYTE_COUNT];
  end

`ifdef RIF_ARB_LOCK_EN
  localparam int unsigned LOCK_CW = $clog2(LOCK_MAX + 1);
  logic               lock_q, regrant, regrant_q;
  logic [LOCK_CW-1:0] lock_cnt;
`else
  logic lock_unused;
  assign lock_unused = (^bus.req_lock) ^ (LOCK_MAX == 0);
`endif

  // Rotating search from rr_ptr; a pending lock overrides it
  always_comb begin
    any_req = 1'b0;
    win     = rr_ptr;
    idx     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!any_req && bus.req_valid[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
`ifdef RIF_ARB_LOCK_EN
    regrant = 1'b0;
    if (lock_q && (lock_cnt < LOCK_CW'(LOCK_MAX)) && bus.req_valid[gnt]) begin
      regrant = 1'b1;
      any_req = 1'b1;
      win     = gnt;
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ack    = '0;
    bus.rif_wr_req = 1'b0;
    bus.rif_rd_req = 1'b0;
    case (state)
      ISSUE: begin
        bus.rif_wr_req = we_q;
        bus.rif_rd_req = ~we_q;
      end
      RESP:    bus.req_ack[gnt] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      rr_ptr  <= '0;
      gnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef RIF_ARB_LOCK_EN
      lock_q    <= 1'b0;
      regrant_q <= 1'b0;
      lock_cnt  <= '0;
`endif
    end else begin
      if (state == IDLE && any_req) begin
        gnt     <= win;
        we_q    <= bus.req_we[win];
        addr_q  <= addr_arr[win];
        wdata_q <= wdata_arr[win];
        wstrb_q <= wstrb_arr[win];
`ifdef RIF_ARB_LOCK_EN
        lock_q    <= bus.req_lock[win];
        regrant_q <= regrant;
        if (!bus.req_lock[win]) lock_cnt <= '0;
        else if (regrant)       lock_cnt <= lock_cnt + LOCK_CW'(1);
        else                    lock_cnt <= LOCK_CW'(1);
`endif
      end
      if (state == ISSUE) begin
        rdata_q <= we_q ? '0 : bus.rif_rdata;
        err_q   <= we_q ? ~bus.rif_wvalid : ~bus.rif_rvalid;
      end
      if (state == RESP) begin
`ifdef RIF_ARB_LOCK_EN
        if (!regrant_q)
`endif
          rr_ptr <= (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + IDX_W'(1);
      end
    end
  end

  assign bus.rif_waddr = addr_q;
  assign bus.rif_raddr = addr_q;
  assign bus.rif_wdata = wdata_q;
  assign bus.rif_wstrb = wstrb_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_rif_arbiter.sv
// Scoreboard bench for rif_arbiter: directed requests, expected strobes/acks queued with cycle stamps.
module tb_rif_arbiter;
  logic aclk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  rif_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  rif_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(32), .LOCK_MAX(2)) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  // Register-file model: 0x010 returns DEADBEEF, others 5A5A5<addr>; 0xFFC is undecoded
  assign bus.rif_rdata  = (bus.rif_raddr == 12'h010) ? 32'hDEADBEEF : {20'h5A5A5, bus.rif_raddr};
  assign bus.rif_rvalid = (bus.rif_raddr != 12'hFFC);
  assign bus.rif_wvalid = (bus.rif_waddr != 12'hFFC);

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } stb_t;

  typedef struct {
    int          cyc;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  req_t rq0[$];
  req_t rq1[$];
  stb_t stb_q[$];
  ack_t ack_q[$];
  stb_t s_m;
  ack_t a_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_req(input int who, input logic we, input logic lock, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r = '{we: we, lock: lock, addr: a, wdata: d, wstrb: s};
    if (who == 0) rq0.push_back(r);
    else          rq1.push_back(r);
  endtask

  task automatic push_stb(input int c, input logic we, input logic [11:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    stb_t e;
    e = '{cyc: c, we: we, addr: a, wdata: d, wstrb: s};
    stb_q.push_back(e);
  endtask

  task automatic push_ack(input int c, input logic [1:0] a, input logic [31:0] d, input logic e);
    ack_t x;
    x = '{cyc: c, ack: a, rdata: d, err: e};
    ack_q.push_back(x);
  endtask

  task automatic set_req(input int i, input logic v, input req_t r);
    bus.req_valid[i]           = v;
    bus.req_we[i]              = r.we;
    bus.req_lock[i]            = r.lock;
    bus.req_addr[i*12 +: 12]   = r.addr;
    bus.req_wdata[i*32 +: 32]  = r.wdata;
    bus.req_wstrb[i*4 +: 4]    = r.wstrb;
  endtask

  task automatic apply();
    req_t z;
    z = '0;
    if (rq0.size() > 0) set_req(0, 1'b1, rq0[0]); else set_req(0, 1'b0, z);
    if (rq1.size() > 0) set_req(1, 1'b1, rq1[0]); else set_req(1, 1'b0, z);
  endtask

  task automatic step();
    @(negedge aclk);
    if (bus.req_ack[0] === 1'b1 && rq0.size() > 0) void'(rq0.pop_front());
    if (bus.req_ack[1] === 1'b1 && rq1.size() > 0) void'(rq1.pop_front());
    apply();
  endtask

  task automatic run(input int budget);
    int k;
    k = 0;
    while (k < budget && (rq0.size() + rq1.size() + stb_q.size() + ack_q.size()) > 0) begin
      step();
      k++;
    end
    step();
    if (stb_q.size() + ack_q.size() > 0) begin
      check("timeout_pending", 64'(stb_q.size() + ack_q.size()), 64'd0);
      stb_q.delete();
      ack_q.delete();
      rq0.delete();
      rq1.delete();
      apply();
    end
  endtask

  // Monitor: every strobe and ack the DUT presents must match the head of its queue
  always @(negedge aclk) begin
    if (mon_en) begin
      if (bus.rif_wr_req === 1'b1 || bus.rif_rd_req === 1'b1) begin
        if (stb_q.size() == 0) begin
          check("unexpected_strobe", {62'd0, bus.rif_wr_req, bus.rif_rd_req}, 64'd0);
        end else begin
          s_m = stb_q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(s_m.cyc));
          check("strobe_kind", {62'd0, bus.rif_wr_req, bus.rif_rd_req}, {62'd0, s_m.we, ~s_m.we});
          check("strobe_addr", s_m.we ? bus.rif_waddr : bus.rif_raddr, s_m.addr);
          if (s_m.we) begin
            check("strobe_wdata", bus.rif_wdata, s_m.wdata);
            check("strobe_wstrb", bus.rif_wstrb, s_m.wstrb);
          end
        end
      end
      if (bus.req_ack !== 2'b00) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", bus.req_ack, 64'd0);
        end else begin
          a_m = ack_q.pop_front();
          check("ack_cycle", 64'(cyc), 64'(a_m.cyc));
          check("ack_vector", bus.req_ack, a_m.ack);
          check("rsp_rdata", bus.rsp_rdata, a_m.rdata);
          check("rsp_err", bus.rsp_err, a_m.err);
        end
      end
    end
  end

  initial begin
    int c0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    repeat (3) @(negedge aclk);

    check("reset_ack", bus.req_ack, 64'd0);
    check("reset_strobes", {62'd0, bus.rif_wr_req, bus.rif_rd_req}, 64'd0);
    check("reset_waddr", bus.rif_waddr, 64'd0);
    check("reset_raddr", bus.rif_raddr, 64'd0);
    check("reset_wdata", bus.rif_wdata, 64'd0);
    check("reset_wstrb", bus.rif_wstrb, 64'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
    check("reset_rsp_err", bus.rsp_err, 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single read by requester 0
    c0 = cyc;
    add_req(0, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0);
    push_stb(c0 + 1, 1'b0, 12'h010, 32'h0, 4'h0);
    push_ack(c0 + 2, 2'b01, 32'hDEADBEEF, 1'b0);
    apply();
    run(20);
    repeat (3) step();
    check("rsp_rdata_hold", bus.rsp_rdata, 64'hDEADBEEF);
    check("raddr_hold", bus.rif_raddr, 64'h010);

    // Reset while the access is in ISSUE; the strobe has gone out, no ack follows
    c0 = cyc;
    add_req(0, 1'b0, 1'b0, 12'h0A4, 32'h0, 4'h0);
    push_stb(c0 + 1, 1'b0, 12'h0A4, 32'h0, 4'h0);
    apply();
    step();
    reset = 1'b1;
    rq0.delete();
    apply();
    step();
    reset = 1'b0;
    check("midrst_ack", bus.req_ack, 64'd0);
    check("midrst_raddr", bus.rif_raddr, 64'd0);
    check("midrst_rsp_rdata", bus.rsp_rdata, 64'd0);
    c0 = cyc;
    add_req(0, 1'b0, 1'b0, 12'h0B0, 32'h0, 4'h0);
    add_req(1, 1'b1, 1'b0, 12'h0C4, 32'hA5A50001, 4'hF);
    push_stb(c0 + 1, 1'b0, 12'h0B0, 32'h0, 4'h0);
    push_ack(c0 + 2, 2'b01, 32'h5A5A50B0, 1'b0);
    push_stb(c0 + 4, 1'b1, 12'h0C4, 32'hA5A50001, 4'hF);
    push_ack(c0 + 5, 2'b10, 32'h0, 1'b0);
    apply();
    run(30);

    // Write to an undecoded address by requester 1
    c0 = cyc;
    add_req(1, 1'b1, 1'b0, 12'hFFC, 32'h12345678, 4'b0011);
    push_stb(c0 + 1, 1'b1, 12'hFFC, 32'h12345678, 4'b0011);
    push_ack(c0 + 2, 2'b10, 32'h0, 1'b1);
    apply();
    run(20);

    // Contention: four requests each, strict alternation
    c0 = cyc;
    add_req(0, 1'b0, 1'b0, 12'h100, 32'h0, 4'h0);
    add_req(0, 1'b0, 1'b0, 12'h104, 32'h0, 4'h0);
    add_req(0, 1'b0, 1'b0, 12'hFFC, 32'h0, 4'h0);
    add_req(0, 1'b1, 1'b0, 12'h108, 32'h000000AA, 4'b0001);
    add_req(1, 1'b1, 1'b0, 12'h200, 32'h11111111, 4'hF);
    add_req(1, 1'b0, 1'b0, 12'h204, 32'h0, 4'h0);
    add_req(1, 1'b1, 1'b0, 12'hFFC, 32'h22222222, 4'b1100);
    add_req(1, 1'b0, 1'b0, 12'h208, 32'h0, 4'h0);
    push_stb(c0 + 1,  1'b0, 12'h100, 32'h0, 4'h0);
    push_ack(c0 + 2,  2'b01, 32'h5A5A5100, 1'b0);
    push_stb(c0 + 4,  1'b1, 12'h200, 32'h11111111, 4'hF);
    push_ack(c0 + 5,  2'b10, 32'h0, 1'b0);
    push_stb(c0 + 7,  1'b0, 12'h104, 32'h0, 4'h0);
    push_ack(c0 + 8,  2'b01, 32'h5A5A5104, 1'b0);
    push_stb(c0 + 10, 1'b0, 12'h204, 32'h0, 4'h0);
    push_ack(c0 + 11, 2'b10, 32'h5A5A5204, 1'b0);
    push_stb(c0 + 13, 1'b0, 12'hFFC, 32'h0, 4'h0);
    push_ack(c0 + 14, 2'b01, 32'h5A5A5FFC, 1'b1);
    push_stb(c0 + 16, 1'b1, 12'hFFC, 32'h22222222, 4'b1100);
    push_ack(c0 + 17, 2'b10, 32'h0, 1'b1);
    push_stb(c0 + 19, 1'b1, 12'h108, 32'h000000AA, 4'b0001);
    push_ack(c0 + 20, 2'b01, 32'h0, 1'b0);
    push_stb(c0 + 22, 1'b0, 12'h208, 32'h0, 4'h0);
    push_ack(c0 + 23, 2'b10, 32'h5A5A5208, 1'b0);
    apply();
    run(60);

    // Requester 0 asks for lock on every request, requester 1 waits
    c0 = cyc;
    add_req(0, 1'b0, 1'b1, 12'h300, 32'h0, 4'h0);
    add_req(0, 1'b0, 1'b1, 12'h304, 32'h0, 4'h0);
    add_req(0, 1'b0, 1'b1, 12'h308, 32'h0, 4'h0);
    add_req(1, 1'b0, 1'b0, 12'h400, 32'h0, 4'h0);
    add_req(1, 1'b0, 1'b0, 12'h404, 32'h0, 4'h0);
`ifdef RIF_ARB_LOCK_EN
    push_stb(c0 + 1,  1'b0, 12'h300, 32'h0, 4'h0);
    push_ack(c0 + 2,  2'b01, 32'h5A5A5300, 1'b0);
    push_stb(c0 + 4,  1'b0, 12'h304, 32'h0, 4'h0);
    push_ack(c0 + 5,  2'b01, 32'h5A5A5304, 1'b0);
    push_stb(c0 + 7,  1'b0, 12'h400, 32'h0, 4'h0);
    push_ack(c0 + 8,  2'b10, 32'h5A5A5400, 1'b0);
    push_stb(c0 + 10, 1'b0, 12'h308, 32'h0, 4'h0);
    push_ack(c0 + 11, 2'b01, 32'h5A5A5308, 1'b0);
    push_stb(c0 + 13, 1'b0, 12'h404, 32'h0, 4'h0);
    push_ack(c0 + 14, 2'b10, 32'h5A5A5404, 1'b0);
`else
    push_stb(c0 + 1,  1'b0, 12'h300, 32'h0, 4'h0);
    push_ack(c0 + 2,  2'b01, 32'h5A5A5300, 1'b0);
    push_stb(c0 + 4,  1'b0, 12'h400, 32'h0, 4'h0);
    push_ack(c0 + 5,  2'b10, 32'h5A5A5400, 1'b0);
    push_stb(c0 + 7,  1'b0, 12'h304, 32'h0, 4'h0);
    push_ack(c0 + 8,  2'b01, 32'h5A5A5304, 1'b0);
    push_stb(c0 + 10, 1'b0, 12'h404, 32'h0, 4'h0);
    push_ack(c0 + 11, 2'b10, 32'h5A5A5404, 1'b0);
    push_stb(c0 + 13, 1'b0, 12'h308, 32'h0, 4'h0);
    push_ack(c0 + 14, 2'b01, 32'h5A5A5308, 1'b0);
`endif
    apply();
    run(40);

    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
